// File: rtl/mw_add_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS 64-bit limbs, LSW first,
// through one shared external adder, with the carry registered between limbs.
module mw_add_seq #(
  parameter int WORDS = 4,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  abort,
  input  logic [WORDS*64-1:0]   op_a,
  input  logic [WORDS*64-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [WORDS*64-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [63:0]           add_a,
  output logic [63:0]           add_b,
  output logic                  add_cin,
  input  logic [63:0]           add_sum,
  input  logic                  add_cout
);
  localparam int            W    = WORDS * 64;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, next_state;
  logic [W-1:0]  a_r, b_r;
  logic          sub_r, carry_r;
  logic [CW-1:0] idx;
  logic          accept, last;
  logic [63:0]   b_limb;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign accept = start && (state != RUN);
  assign last   = (idx == LAST);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign b_limb = b_r[idx*64 +: 64];

  // Adder inputs are driven only while a limb is in flight.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_r[idx*64 +: 64];
      add_b   = sub_r ? ~b_limb : b_limb;
      add_cin = carry_r;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (abort)     next_state = IDLE;
        else if (last) next_state = DONE;
      end
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Abort wins over the last-limb write, so an aborted limb is never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      carry_r   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_r       <= op_a;
      b_r       <= op_b;
      sub_r     <= sub;
      carry_r   <= sub;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == RUN && !abort) begin
      result[idx*64 +: 64] <= add_sum;
      carry_r              <= add_cout;
      if (last) begin
        carry_out <= add_cout;
        overflow  <= signed_ovf(add_a[63], add_b[63], add_sum[63]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mw_add_seq.sv
// Scoreboard bench for mw_add_seq: a behavioural adder stands in for the shared CLA,
// expected results are queued at issue and popped by a monitor on each done pulse.
module tb_mw_add_seq;
  localparam int WORDS = 4;
  localparam int CW    = 4;
  localparam int W     = WORDS * 64;

  logic          clk = 1'b0;
  logic          rst_n, start, sub, abort;
  logic [W-1:0]  op_a, op_b, result;
  logic          busy, done, carry_out, overflow;
  logic [63:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;

  mw_add_seq #(.WORDS(WORDS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .abort(abort),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Shared combinational adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic signed [W+1:0] sa, sb, full;
    sa   = $signed({a[W-1], a[W-1], a});
    sb   = $signed({b[W-1], b[W-1], b});
    full = s ? sa - sb : sa + sb;
    e.r  = s ? a - b : a + b;
    e.c  = s ? (a >= b) : (({1'b0, a} + {1'b0, b}) >> W) != 0;
    e.o  = !((full[W+1] == full[W]) && (full[W] == full[W-1]));
    return e;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: got done=1 expected no done");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_result", result, e.r);
        check("sb_carry_out", {{(W-1){1'b0}}, carry_out}, {{(W-1){1'b0}}, e.c});
        check("sb_overflow", {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, e.o});
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit expect_done);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    if (expect_done) q.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: got no done after %0d cycles expected done", budget);
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done === 1'b1) cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [3:0]   cins;
    exp_t         e;
    int           n;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; abort = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {255'd0, busy}, '0);
    check("rst_done", {255'd0, done}, '0);
    check("rst_result", result, '0);
    check("rst_flags", {254'd0, carry_out, overflow}, '0);
    check("rst_adder", {127'd0, add_a, add_b, add_cin}, '0);
    rst_n = 1'b1;

    // All-ones + 1: latency and carry chain
    issue('1, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cins[i] = add_cin;
      check("run_busy", {255'd0, busy}, 1);
      check("run_no_done", {255'd0, done}, '0);
      @(negedge clk);
    end
    check("cin_seq", {252'd0, cins}, 4'b1110);
    check("done_cycle5", {255'd0, done}, 1);
    @(negedge clk);
    check("done_one_cycle", {255'd0, done}, '0);
    check("hold_carry", {255'd0, carry_out}, 1);

    // 0 - 1: first-limb drive
    issue('0, 1, 1'b1, 1'b1);
    check("sub_add_b0", {192'd0, add_b}, {192'd0, 64'hFFFF_FFFF_FFFF_FFFE});
    check("sub_cin0", {255'd0, add_cin}, 1);
    wait_done(10);

    // Inter-limb carry
    issue({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 1'b0, 1'b1);
    wait_done(10);
    @(negedge clk);
    check("interlimb", result, {128'd0, 64'd1, 64'd0});

    // Signed overflow both directions
    a = '1; a[W-1] = 1'b0;
    issue(a, 1, 1'b0, 1'b1);
    wait_done(10);
    a = '0; a[W-1] = 1'b1;
    issue(a, 1, 1'b1, 1'b1);
    wait_done(10);

    // Random operations
    for (int k = 0; k < 24; k++) begin
      a = rand_w();
      b = rand_w();
      if (k % 6 == 0) b = a;
      if (k % 6 == 1) b = ~a;
      issue(a, b, 1'($urandom_range(0, 1)), 1'b1);
      wait_done(10);
    end

    // start during RUN is ignored
    issue(rand_w(), rand_w(), 1'b0, 1'b1);
    start = 1'b1; op_a = rand_w(); op_b = rand_w(); sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(12, n);
    check("ignored_start_dones", W'(n), W'(1));

    // start in the DONE cycle is accepted
    issue(rand_w(), rand_w(), 1'b1, 1'b1);
    wait_done(10);
    a = rand_w(); b = rand_w();
    start = 1'b1; op_a = a; op_b = b; sub = 1'b0;
    q.push_back(model(a, b, 1'b0));
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) n = i;
    end
    check("b2b_done_at5", W'(n), W'(5));

    // abort in RUN cycle 2
    a = rand_w(); b = rand_w();
    e = model(a, b, 1'b0);
    issue(a, b, 1'b0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {255'd0, busy}, '0);
    check("abort_partial", result, {192'd0, e.r[63:0]});
    check("abort_flags", {254'd0, carry_out, overflow}, '0);
    count_dones(8, n);
    check("abort_no_done", W'(n), '0);

    // async reset mid-RUN
    issue(rand_w(), rand_w(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {255'd0, busy}, '0);
    check("arst_result", result, '0);
    check("arst_adder", {127'd0, add_a, add_b, add_cin}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(8, n);
    check("arst_no_done", W'(n), '0);

    check("queue_empty", W'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
